// File: rtl/window_pkg.sv
// Shared geometry defaults and the pixel lane-index helper for the window
// generator and its per-row shift registers.
package window_pkg;

    // Default frame geometry of the plate-recognition pipeline.
    localparam int IM_WIDTH    = 320;
    localparam int IM_HEIGHT   = 240;
    localparam int COLOR_WIDTH = 12;

    // Lane of pixel (r,c) in the flattened window; r=0 is the top row and
    // c=0 the leftmost (oldest) column.
    function automatic int lane(input int r, input int c, input int cols_width);
        return r * cols_width + c;
    endfunction

endpackage

// File: rtl/window_row_shift.sv
// One window row: cols_width pixels shifted left on each enabled beat, with
// the newest pixel entering at c=cols_width-1. The post-shift value is also
// exported so the parent can capture a finished window on the same edge.
module window_row_shift #(
    parameter int cols_width  = 3,
    parameter int color_width = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [color_width-1:0]            pix_in,
    output logic [cols_width*color_width-1:0] win_nxt
);

    logic [cols_width*color_width-1:0] row_q;

    // Column c takes the old column c+1; the incoming pixel lands at the top.
    assign win_nxt = {pix_in, row_q[cols_width*color_width-1:color_width]};

    // Shift only on accepted beats so idle gaps leave the row untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            row_q <= '0;
        else if (en)
            row_q <= win_nxt;
    end

endmodule

// File: rtl/window_generator.sv
// Builds a rows_width x cols_width pixel window from the parallel column
// stream of the rows generator and tags it with its image coordinates.
// Windows never straddle a line: the first cols_width-1 beats of every line
// only prime the shift registers.
// Optional build macro WINDOW_ZERO_GATE_EN: out_data/out_col/out_row read 0
// while out_ready is low; without it they hold the last window.
module window_generator
    import window_pkg::*;
#(
    parameter int rows_width     = 3,
    parameter int cols_width     = 3,
    parameter int im_width       = IM_WIDTH,
    parameter int im_height      = IM_HEIGHT,
    parameter int color_width    = COLOR_WIDTH,
    parameter int im_width_bits  = 9,
    parameter int im_height_bits = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_enable,
    input  logic [rows_width*color_width-1:0]            in_data,
    output logic                                         out_ready,
    output logic [rows_width*cols_width*color_width-1:0] out_data,
    output logic [im_width_bits-1:0]                     out_col,
    output logic [im_height_bits-1:0]                    out_row,
    output logic                                         frame_done
);

    localparam int ROW_BITS = cols_width * color_width;
    localparam int WIN_BITS = rows_width * ROW_BITS;

    // First column index whose beat completes a window, last column of a
    // line, and last line index that still has a full row pack below it.
    localparam logic [im_width_bits-1:0]  COL_FIRST = im_width_bits'(cols_width - 1);
    localparam logic [im_width_bits-1:0]  COL_LAST  = im_width_bits'(im_width - 1);
    localparam logic [im_height_bits-1:0] LINE_LAST = im_height_bits'(im_height - rows_width);

    logic [im_width_bits-1:0]  col_cnt;
    logic [im_height_bits-1:0] line_cnt;
    logic [WIN_BITS-1:0]       win_nxt;
    logic                      win_fire;
    logic                      last_win;

    logic                      ready_q;
    logic                      frame_done_q;
    logic [WIN_BITS-1:0]       data_q;
    logic [im_width_bits-1:0]  col_q;
    logic [im_height_bits-1:0] row_q;

    // One shift register per window row; row r sits at lane r*cols_width.
    genvar r;
    generate
        for (r = 0; r < rows_width; r++) begin : g_row
            window_row_shift #(
                .cols_width  (cols_width),
                .color_width (color_width)
            ) u_row (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (in_enable),
                .pix_in  (in_data[r*color_width +: color_width]),
                .win_nxt (win_nxt[lane(r, 0, cols_width)*color_width +: ROW_BITS])
            );
        end
    endgenerate

    // A beat completes a window once the line has supplied cols_width columns;
    // the compare uses the column count before this beat's increment.
    assign win_fire = in_enable && (col_cnt >= COL_FIRST);
    assign last_win = (line_cnt == LINE_LAST) && (col_cnt == COL_LAST);

    // Column / line position; both wrap at their limits so they never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            line_cnt <= '0;
        end else if (in_enable) begin
            if (col_cnt == COL_LAST) begin
                col_cnt  <= '0;
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Registered window output: captured only on producing beats, so the
    // priming beats of a new line do not disturb the last emitted window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            ready_q      <= win_fire;
            frame_done_q <= win_fire && last_win;
            if (win_fire) begin
                data_q <= win_nxt;
                col_q  <= col_cnt - COL_FIRST;
                row_q  <= line_cnt;
            end
        end
    end

    assign out_ready  = ready_q;
    assign frame_done = frame_done_q;

`ifdef WINDOW_ZERO_GATE_EN
    // Downstream sees zeros whenever no window is being presented.
    assign out_data = ready_q ? data_q : '0;
    assign out_col  = ready_q ? col_q  : '0;
    assign out_row  = ready_q ? row_q  : '0;
`else
    // Outputs hold the last window and its coordinates between windows.
    assign out_data = data_q;
    assign out_col  = col_q;
    assign out_row  = row_q;
`endif

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator at default geometry. A line-buffer
// model derives every expected window from the accepted column stream, a
// per-cycle compare process checks it, and literal checks pin the model.
module tb_window_generator;
    import window_pkg::*;

    localparam int R  = 3;
    localparam int C  = 3;
    localparam int W  = 320;
    localparam int H  = 240;
    localparam int CW = 12;
    localparam int DW = R * C * CW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_enable = 1'b0;
    logic [R*CW-1:0] in_data = '0;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [8:0]      out_col;
    logic [7:0]      out_row;
    logic            frame_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    window_generator #(
        .rows_width(R), .cols_width(C), .im_width(W), .im_height(H),
        .color_width(CW), .im_width_bits(9), .im_height_bits(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_enable  (in_enable),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_row    (out_row),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Pixel of row r, beat k, absolute line L; lines differ so stale data shows.
    function automatic logic [CW-1:0] pix(input int r, input int k, input int L);
        return {2'(r), 10'(k + 320 * (L % 3))};
    endfunction

    function automatic logic [CW-1:0] px(input logic [DW-1:0] d, input int r, input int c);
        return d[lane(r, c, C)*CW +: CW];
    endfunction

    // ---------------- behavioural model ----------------
    logic [R*CW-1:0] linebuf [W];
    int              m_k, m_line;
    logic            exp_v, exp_fd;
    logic [DW-1:0]   exp_data;
    int              exp_col, exp_row;

    // Window whose leftmost column is beat j of the current line; the newest
    // column is the beat being accepted right now.
    function automatic logic [DW-1:0] build_win(input int j, input logic [R*CW-1:0] cur);
        logic [DW-1:0]   w;
        logic [R*CW-1:0] colv;
        w = '0;
        for (int c = 0; c < C; c++) begin
            colv = (c == C - 1) ? cur : linebuf[j + c];
            for (int r = 0; r < R; r++) w[lane(r, c, C)*CW +: CW] = colv[r*CW +: CW];
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_line <= 0; exp_v <= 1'b0; exp_fd <= 1'b0;
            exp_data <= '0; exp_col <= 0; exp_row <= 0;
        end else begin
            exp_v  <= 1'b0;
            exp_fd <= 1'b0;
            if (in_enable) begin
                linebuf[m_k] <= in_data;
                if (m_k >= C - 1) begin
                    exp_v    <= 1'b1;
                    exp_col  <= m_k - (C - 1);
                    exp_row  <= m_line;
                    exp_fd   <= (m_line == H - R) && (m_k == W - 1);
                    exp_data <= build_win(m_k - (C - 1), in_data);
                end
                if (m_k == W - 1) begin
                    m_k    <= 0;
                    m_line <= (m_line == H - R) ? 0 : m_line + 1;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_ready", out_ready, exp_v);
            chk("frame_done", frame_done, exp_fd);
            if (exp_v) begin
                chk("win_data", out_data, exp_data);
                chk("win_col", out_col, exp_col);
                chk("win_row", out_row, exp_row);
            end else begin
`ifdef WINDOW_ZERO_GATE_EN
                chk("gap_data_zero", out_data, '0);
                chk("gap_col_zero", out_col, '0);
                chk("gap_row_zero", out_row, '0);
`else
                chk("gap_data_hold", out_data, exp_data);
                chk("gap_col_hold", out_col, exp_col);
                chk("gap_row_hold", out_row, exp_row);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input int L, input int k);
        for (int r = 0; r < R; r++) in_data[r*CW +: CW] = pix(r, k, L);
        in_enable = 1'b1;
        @(negedge clk);
        in_enable = 1'b0;
    endtask

    task automatic idle();
        in_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Part of a line, then an asynchronous reset away from any clock edge.
        for (int k = 0; k < 150; k++) beat(0, k);
        chk("pre_rst_col", out_col, 9'd147);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ready", out_ready, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_col", out_col, '0);
        chk("rst_row", out_row, '0);
        chk("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Full frame plus the first line of the next; line 2 is gapped 1-in-3.
        for (int L = 0; L <= H - R + 1; L++) begin
            for (int k = 0; k < W; k++) begin
                beat(L, k);
                if (L == 2) begin
                    idle();
                    idle();
                end
                if (L == 0 && k == 1) chk("l0_k1_no_win", out_ready, 1'b0);
                if (L == 0 && k == 2) begin
                    chk("l0_first_ready", out_ready, 1'b1);
                    chk("l0_first_col", out_col, 9'd0);
                    chk("l0_first_row", out_row, 8'd0);
                    chk("l0_px00", px(out_data, 0, 0), 12'h000);
                    chk("l0_px11", px(out_data, 1, 1), 12'h401);
                    chk("l0_px22", px(out_data, 2, 2), 12'h802);
                end
                if (L == 1 && k == 1) chk("l1_k1_no_win", out_ready, 1'b0);
                if (L == 1 && k == 2) begin
                    chk("l1_first_row", out_row, 8'd1);
                    chk("l1_first_col", out_col, 9'd0);
                    chk("l1_px00", px(out_data, 0, 0), 12'h140);
                    chk("l1_px02", px(out_data, 0, 2), 12'h142);
                    chk("l1_px20", px(out_data, 2, 0), 12'h940);
                end
                if (L == 2 && k == 3) begin
                    chk("gap_ready", out_ready, 1'b0);
`ifdef WINDOW_ZERO_GATE_EN
                    chk("gap_px00_zero", px(out_data, 0, 0), 12'h000);
`else
                    chk("gap_px00_hold", px(out_data, 0, 0), 12'h281);
`endif
                end
                if (L == H - R && k == W - 1) begin
                    chk("last_frame_done", frame_done, 1'b1);
                    chk("last_col", out_col, 9'd317);
                    chk("last_row", out_row, 8'd237);
                end
                if (L == H - R + 1 && k == 2) begin
                    chk("next_frame_row", out_row, 8'd0);
                    chk("next_frame_fd", frame_done, 1'b0);
                    chk("next_frame_px00", px(out_data, 0, 0), 12'h140);
                end
            end
        end

        repeat (4) idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
- Consumes the parallel multi-row column stream produced by the rows generator and builds a rows_width x cols_width pixel window for neighbourhood filters (erode/dilate, Sobel, median) in the plate-recognition pipeline.
- Tracks column and line position so that no emitted window spans two lines or two frames.
- Tags every window with its coordinates.

Parameters:
- rows_width, 3, window height; must equal the upstream rows generator's rows_width.
- cols_width, 3, window width, 2..15.
- im_width, 320, pixels per line.
- im_height, 240, lines per frame.
- color_width, 12, bits per pixel.
- im_width_bits, 9, column counter width.
- im_height_bits, 8, line counter width.

Ports:
- clk  in  1  rising-edge clock; the single clock of the block.
- rst_n  in  1  reset; asynchronous, active-low.
- in_enable  in  1  in_data valid this cycle; wired to the upstream out_ready.
- in_data  in  rows_width*color_width  one column; lane r is bits [(r+1)*color_width-1 : r*color_width], r=0 is the top (oldest) row.
- out_ready  out  1  out_data, out_col and out_row hold a valid window this cycle.
- out_data  out  rows_width*cols_width*color_width  window; pixel (r,c) is at lane r*cols_width+c; c=0 is the leftmost (oldest) column.
- out_col  out  im_width_bits  image column of the window's leftmost pixel.
- out_row  out  im_height_bits  image row of the window's top pixel.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset values: out_ready=0, frame_done=0, out_data=0, out_col=0, out_row=0. Window registers, col_cnt and line_cnt also clear to 0. Reset takes effect immediately, including mid-line; the next frame starts at col 0, line 0.
- There is no backpressure. Every in_enable beat is accepted. Gaps of any length are legal and change no state.
- On an accepted beat:
  - Each row's column shift register shifts left, and the new column enters at c=cols_width-1.
  - col_cnt increments, wrapping from im_width-1 to 0.
  - On that wrap, line_cnt increments, wrapping from im_height-rows_width to 0.
- Window valid rule: a beat accepted with col_cnt >= cols_width-1 (value before the increment) produces a window.
  - Latency is 1 cycle: out_ready is registered and is high the cycle after the producing beat, low otherwise.
  - out_col = col_cnt-(cols_width-1). out_row = line_cnt.
- Counts:
  - Windows per line: im_width-cols_width+1 (318 at defaults).
  - Line packs per frame: im_height-rows_width+1 (238 at defaults).
- Line boundary: the first cols_width-1 beats of each line only fill the shift registers. Stale columns from the previous line never appear in a valid window.
- frame_done is high with out_ready when out_row = im_height-rows_width and out_col = im_width-cols_width.
- Back-to-back beats produce back-to-back windows. Window registers are updated only on accepted beats.
- col_cnt and line_cnt never exceed their wrap limits, so no counter overflow is possible.

Optional Feature:
- WINDOW_ZERO_GATE_EN defined: out_data, out_col and out_row read 0 whenever out_ready=0 (combinational gate on the registered values).
- Not defined: these outputs hold the last window and its coordinates until the next window.

Decomposition:
- Shared package (window_pkg):
  - pixel lane-index function lane(r,c,cols_width).
  - default geometry constants (IM_WIDTH, IM_HEIGHT, COLOR_WIDTH).
- Sub-module window_row_shift: one row's cols_width x color_width shift register with an enable. It is instantiated rows_width times in a generate loop. Counters and valid/position logic stay in window_generator.

Test Plan:
1. Reset: drop rst_n while mid-line (col 150), with no clock edge -> out_ready=0 and out_data=0 at once. After release, 2 beats give no window and the 3rd beat gives out_ready the next cycle with out_col=0, out_row=0.
2. Full line at defaults: beat k drives lane r = {r[1:0], k[9:0]} -> 318 windows. The window with out_col=j has pixel (r,c) = {r, j+c}. The first window comes 1 cycle after beat 2.
3. Gapped input: in_enable high every 3rd cycle over one line -> same 318 windows in the same order, each exactly 1 cycle after its producing beat, none during gaps.
4. Line wrap: a second line directly follows the first -> no out_ready after its beats 0 and 1. The first window of line 2 has out_row=1, out_col=0, and no pixel from line 1.
5. Frame end: 238 line packs -> frame_done=1 only with the window out_row=237, out_col=317. The next line's first window has out_row=0.
6. Macro: run scenario 3 with WINDOW_ZERO_GATE_EN -> out_data=0 during gaps. Without the macro -> out_data holds the previous window during gaps.
